// File: rtl/itof_pipe_pkg.sv
// fpu_pkg: shared single-precision constants, result layout and
// the round-to-nearest-even increment decision.
package fpu_pkg;

  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = 23;
  localparam int EXP_W    = 8;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } float_t;

  function automatic logic rne_inc(
    input logic lsb,
    input logic g,
    input logic r,
    input logic s
  );
    return g & (r | s | lsb);
  endfunction

endpackage

// File: rtl/itof_pipe_if.sv
// itof_pipe_if: operand/result valid-ready bundle.
// master = producer/consumer side, slave = converter side.
interface itof_pipe_if #(
  parameter int IN_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;
  logic            in_unsigned;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_data;
  logic            out_inexact;

  modport master (
    output in_valid, in_data, in_unsigned, out_ready,
    input  in_ready, out_valid, out_data, out_inexact
  );

  modport slave (
    input  in_valid, in_data, in_unsigned, out_ready,
    output in_ready, out_valid, out_data, out_inexact
  );
endinterface

// File: rtl/itof_pipe_lzc.sv
// lzc: combinational leading-zero counter.
// d: operand; cnt: zeros above the first set bit (WIDTH if d == 0).
module lzc #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] d,
  output logic [CW-1:0]    cnt
);
  logic found;

  always_comb begin
    cnt   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found) begin
        if (d[i]) found = 1'b1;
        else      cnt   = cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/itof_pipe.sv
// itof_pipe: 3-stage integer to IEEE-754 single converter, RNE.
// Ports: clk, rstn (async low), io (itof_pipe_if.slave handshake).
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 32
) (
  input  logic       clk,
  input  logic       rstn,
  itof_pipe_if.slave io
);
  localparam int LW = $clog2(IN_W + 1);
  localparam int FW = IN_W + 24;

  if (OUT_W != 32 || IN_W < 8 || IN_W > 64) begin : g_bad_cfg
    $error("itof_pipe: OUT_W must be 32, IN_W 8..64");
  end

  logic adv;
  logic s1_valid, s2_valid, s3_valid;

  // Single global enable: bubbles hold too.
  assign adv         = !s3_valid || io.out_ready;
  assign io.in_ready = adv;

  // S1: sign and magnitude
  logic            in_sign;
  logic            s1_sign;
  logic [IN_W-1:0] s1_mag;

  assign in_sign = !io.in_unsigned && io.in_data[IN_W-1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
    end else if (adv) begin
      s1_valid <= io.in_valid;
      s1_sign  <= in_sign;
      s1_mag   <= in_sign ? -io.in_data : io.in_data;
    end
  end

  // S2: normalise
  logic [LW-1:0]    lz;
  logic [IN_W-1:0]  shifted;
  logic             s2_sign;
  logic             s2_zero;
  logic [EXP_W-1:0] s2_exp;
  logic [IN_W-2:0]  s2_frac;

  lzc #(.WIDTH(IN_W)) u_lzc (
    .d   (s1_mag),
    .cnt (lz)
  );

  assign shifted = s1_mag << lz;

  // The hidden bit is set after normalising iff mag != 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_exp   <= '0;
      s2_frac  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= !shifted[IN_W-1];
      s2_exp   <= EXP_W'(EXP_BIAS + IN_W - 1 - int'(lz));
      s2_frac  <= shifted[IN_W-2:0];
    end
  end

  // S3: round and pack
  // Zero padding makes G/R/S vanish for narrow operands.
  logic [FW-1:0]     ext;
  logic [MANT_W-1:0] mant;
  logic              g, r, st, inc;
  logic [MANT_W:0]   mant_r;
  float_t            res;
  logic [31:0]       s3_data;
  logic              s3_inex;

  assign ext    = {s2_frac, 25'd0};
  assign mant   = ext[FW-1 -: MANT_W];
  assign g      = ext[FW-24];
  assign r      = ext[FW-25];
  assign st     = |ext[FW-26:0];
  assign inc    = rne_inc(mant[0], g, r, st);
  assign mant_r = {1'b0, mant} + {{MANT_W{1'b0}}, inc};

  always_comb begin
    res = '0;
    if (!s2_zero) begin
      res.sign = s2_sign;
      res.exp  = s2_exp + EXP_W'(mant_r[MANT_W]);
      res.mant = mant_r[MANT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s3_valid <= 1'b0;
      s3_data  <= '0;
      s3_inex  <= 1'b0;
    end else if (adv) begin
      s3_valid <= s2_valid;
      s3_data  <= res;
      s3_inex  <= g | r | st;
    end
  end

  assign io.out_valid   = s3_valid;
  assign io.out_data    = s3_data;
  assign io.out_inexact = s3_inex;
endmodule

// File: tb/tb_itof_pipe.sv
// tb_itof_pipe: directed + random checks of itof_pipe at
// IN_W = 32, 16 and 64 against an arithmetic reference model.
module tb_itof_pipe;
  typedef struct packed {
    logic [31:0] cyc;
    logic [32:0] v;
  } ent_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  ent_t expq[3][$];
  ent_t gotq[3][$];

  itof_pipe_if #(.IN_W(32)) b32();
  itof_pipe_if #(.IN_W(16)) b16();
  itof_pipe_if #(.IN_W(64)) b64();

  itof_pipe #(.IN_W(32), .OUT_W(32)) u32 (
    .clk(clk), .rstn(rstn), .io(b32.slave));
  itof_pipe #(.IN_W(16), .OUT_W(32)) u16 (
    .clk(clk), .rstn(rstn), .io(b16.slave));
  itof_pipe #(.IN_W(64), .OUT_W(32)) u64 (
    .clk(clk), .rstn(rstn), .io(b64.slave));

  // Reference: exact magnitude, then RNE by remainder vs half ulp.
  function automatic logic [32:0] ref_cvt(
    input logic [63:0] x, input int w, input logic uns);
    logic [64:0] m, q, rem, half;
    logic        s;
    int          e, sh;
    s   = !uns && x[w-1];
    m   = s ? ((65'd1 << w) - {1'b0, x}) : {1'b0, x};
    rem = '0;
    if (m == 0) return '0;
    e = 0;
    for (int i = 0; i < 65; i++) if (m[i]) e = i;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      sh   = e - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 65'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q[24]) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    return {rem != 0, s, 8'(e + 127), q[22:0]};
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      if (b32.in_valid && b32.in_ready)
        expq[0].push_back('{32'(cyc),
          ref_cvt(64'(b32.in_data), 32, b32.in_unsigned)});
      if (b16.in_valid && b16.in_ready)
        expq[1].push_back('{32'(cyc),
          ref_cvt(64'(b16.in_data), 16, b16.in_unsigned)});
      if (b64.in_valid && b64.in_ready)
        expq[2].push_back('{32'(cyc),
          ref_cvt(b64.in_data, 64, b64.in_unsigned)});
      if (b32.out_valid && b32.out_ready)
        gotq[0].push_back('{32'(cyc), {b32.out_inexact, b32.out_data}});
      if (b16.out_valid && b16.out_ready)
        gotq[1].push_back('{32'(cyc), {b16.out_inexact, b16.out_data}});
      if (b64.out_valid && b64.out_ready)
        gotq[2].push_back('{32'(cyc), {b64.out_inexact, b64.out_data}});
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d,
                       input logic u);
    b32.in_valid = v; b32.in_data = d[31:0]; b32.in_unsigned = u;
    b16.in_valid = v; b16.in_data = d[15:0]; b16.in_unsigned = u;
    b64.in_valid = v; b64.in_data = d;       b64.in_unsigned = u;
  endtask

  task automatic set_ready(input logic r);
    b32.out_ready = r;
    b16.out_ready = r;
    b64.out_ready = r;
  endtask

  task automatic check_stream(input int k, input bit lat);
    ent_t g, e;
    check($sformatf("count_w%0d", k), 64'(gotq[k].size()),
          64'(expq[k].size()));
    while (gotq[k].size() > 0 && expq[k].size() > 0) begin
      g = gotq[k].pop_front();
      e = expq[k].pop_front();
      check($sformatf("result_w%0d", k), 64'(g.v), 64'(e.v));
      if (lat) check($sformatf("latency_w%0d", k),
                     64'(g.cyc - e.cyc), 64'd3);
    end
    gotq[k].delete();
    expq[k].delete();
  endtask

  logic [63:0] dv[9] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
    64'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'd16777217,
    64'd16777219, 64'hFFFF_FFFF, 64'h8000_0000};
  logic        du[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
  logic [32:0] dexp[9] = '{33'h0_0000_0000, 33'h0_BF80_0000,
    33'h0_3F80_0000, 33'h1_4F00_0000, 33'h0_CF00_0000,
    33'h1_4B80_0000, 33'h1_4B80_0002, 33'h1_4F80_0000,
    33'h0_4F00_0000};
  logic [63:0] spec[5] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
    64'hFFFF_FFFF_8000_0000, 64'h8000_0000_0000_0000,
    64'hFFFF_FFFF_FFFF_8000};

  initial begin
    logic [63:0] bv[5];
    logic [63:0] d;
    logic [31:0] held;
    int          acc;
    logic        flag;

    drive(0, '0, 0);
    set_ready(1);
    #1 rstn = 1'b0;
    #2;
    check("rst_out_valid", 64'(b32.out_valid), 64'd0);
    check("rst_out_data", 64'(b32.out_data), 64'd0);
    check("rst_out_inexact", 64'(b32.out_inexact), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    tick();
    check("post_rst_valid", 64'(b32.out_valid), 64'd0);
    check("post_rst_in_ready", 64'(b32.in_ready), 64'd1);

    // Directed stream, out_ready held high
    for (int i = 0; i < 9; i++) begin
      drive(1, dv[i], du[i]);
      tick();
    end
    drive(0, '0, 0);
    repeat (8) tick();
    if (gotq[0].size() == 9)
      for (int i = 0; i < 9; i++)
        check($sformatf("directed_%0d", i),
              64'(gotq[0][i].v), 64'(dexp[i]));
    for (int k = 0; k < 3; k++) check_stream(k, 1);

    // Backpressure
    for (int i = 0; i < 5; i++) bv[i] = {$urandom, $urandom};
    set_ready(0);
    acc = 0;
    drive(1, bv[0], 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (b32.in_ready) acc++;
      tick();
      if (acc < 5) drive(1, bv[acc], 0);
      else         drive(0, '0, 0);
    end
    check("bp_accepted", 64'(acc), 64'd3);
    check("bp_in_ready", 64'(b32.in_ready), 64'd0);
    check("bp_out_valid", 64'(b32.out_valid), 64'd1);
    held = b32.out_data;
    repeat (3) tick();
    check("bp_hold", 64'(b32.out_data), 64'(held));
    set_ready(1);
    for (int c = 0; c < 20 && acc < 5; c++) begin
      @(negedge clk);
      if (b32.in_ready) acc++;
      tick();
      if (acc < 5) drive(1, bv[acc], 0);
      else         drive(0, '0, 0);
    end
    drive(0, '0, 0);
    check("bp_all_accepted", 64'(acc), 64'd5);
    repeat (8) tick();
    for (int k = 0; k < 3; k++) check_stream(k, 0);

    // Reset with three results in flight
    for (int i = 0; i < 3; i++) begin
      drive(1, {$urandom, $urandom}, 0);
      tick();
    end
    check("pre_rst_valid", 64'(b32.out_valid), 64'd1);
    #1;
    rstn = 1'b0;
    drive(0, '0, 0);
    #1;
    check("mid_rst_valid32", 64'(b32.out_valid), 64'd0);
    check("mid_rst_valid16", 64'(b16.out_valid), 64'd0);
    check("mid_rst_valid64", 64'(b64.out_valid), 64'd0);
    check("mid_rst_data", 64'(b32.out_data), 64'd0);
    for (int k = 0; k < 3; k++) begin
      expq[k].delete();
      gotq[k].delete();
    end
    repeat (2) tick();
    rstn = 1'b1;
    flag = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (b32.out_valid || b16.out_valid || b64.out_valid)
        flag = 1'b1;
    end
    check("post_rst_quiet", 64'(flag), 64'd0);
    check("post_rst_no_out", 64'(gotq[0].size()), 64'd0);
    tick();

    // Random traffic with random stalls on both sides
    for (int n = 0; n < 12000; n++) begin
      case ($urandom_range(0, 7))
        0: begin
          d = 64'($urandom_range(0, 300));
          if ($urandom_range(0, 1) == 1) d = -d;
        end
        1: d = spec[$urandom_range(0, 4)];
        default: d = {$urandom, $urandom};
      endcase
      drive($urandom_range(0, 7) != 0, d, 1'($urandom_range(0, 1)));
      set_ready($urandom_range(0, 7) != 0);
      tick();
    end
    drive(0, '0, 0);
    set_ready(1);
    repeat (10) tick();
    for (int k = 0; k < 3; k++) check_stream(k, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
